// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher with a small prefetch queue.
//
// Fetches 32-bit words from a synchronous instruction memory (one-cycle read latency) inside an
// 8 KB window that starts at RESET_PC. Fetched words are queued and presented to the consumer
// with a valid/ready handshake. A redirect flushes the queue, kills any fetch in flight and
// restarts fetching at the new PC. An illegal PC (misaligned or outside the window) queues a
// single address-error marker and halts fetching until the next redirect.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   im_en, im_addr    memory read request and word address (pc[12:2])
//   im_dout           memory read data, one cycle after im_en
//   redirect,
//   redirect_pc       restart fetching at redirect_pc
//   inst_valid,
//   inst_ready        head-of-queue handshake
//   inst, inst_pc,
//   inst_err          head instruction, its byte PC, address-error marker
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_en,
  output logic [12:2] im_addr,
  input  logic [31:0] im_dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err
);

  localparam logic [31:0] WINDOW    = 32'h0000_2000;
  localparam int unsigned CW        = 3;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  typedef enum logic [0:0] {StFetch, StHalt} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    inflight_q, inflight_d;
  logic [31:0]             tag_q, tag_d;
  logic [DEPTH-1:0][31:0]  f_inst_q, f_inst_d;
  logic [DEPTH-1:0][31:0]  f_pc_q, f_pc_d;
  logic [DEPTH-1:0]        f_err_q, f_err_d;

  logic [31:0]   pc_off;
  logic          pc_legal;
  logic          pop;
  logic [CW:0]   occ;
  logic          has_room;
  logic          in_fetch;
  logic          issue;
  logic          err_push;
  logic [CW-1:0] wr;

  // Unsigned offset from the window base covers both bounds in one compare.
  assign pc_off   = pc_q - RESET_PC;
  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_off < WINDOW);

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid & inst_ready & ~redirect;

  // Entries held after this cycle's pop, counting the fetch that lands next cycle.
  assign occ      = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign has_room = (occ < DEPTH_OCC);
  assign in_fetch = (state_q == StFetch);
  assign issue    = ~redirect & in_fetch & pc_legal & has_room;
  assign err_push = ~redirect & in_fetch & ~pc_legal & has_room;

  // Flops are already held in reset; only the memory request needs explicit gating.
  assign im_en   = issue & rst_n;
  assign im_addr = pc_q[12:2];

  assign inst    = inst_valid ? f_inst_q[0] : '0;
  assign inst_pc = inst_valid ? f_pc_q[0]   : '0;
  assign inst_err = inst_valid & f_err_q[0];

  // PC, FSM and in-flight tracking.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = StFetch;
    end else begin
      if (issue) begin
        pc_d       = pc_q + 32'd4;
        inflight_d = 1'b1;
        tag_d      = pc_q;
      end
      if (err_push) begin
        state_d = StHalt;
      end
    end
  end

  // Shift-register queue: head at index 0, entries at and above count are kept zero.
  // The returning fetch is older than an error marker pushed in the same cycle, so it
  // is written first.
  always_comb begin
    f_inst_d = f_inst_q;
    f_pc_d   = f_pc_q;
    f_err_d  = f_err_q;
    count_d  = count_q;
    wr       = count_q - CW'(pop);
    if (redirect) begin
      f_inst_d = '0;
      f_pc_d   = '0;
      f_err_d  = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          f_inst_d[i] = f_inst_q[i+1];
          f_pc_d[i]   = f_pc_q[i+1];
          f_err_d[i]  = f_err_q[i+1];
        end
        f_inst_d[DEPTH-1] = '0;
        f_pc_d[DEPTH-1]   = '0;
        f_err_d[DEPTH-1]  = 1'b0;
      end
      if (inflight_q) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr) begin
            f_inst_d[i] = im_dout;
            f_pc_d[i]   = tag_q;
            f_err_d[i]  = 1'b0;
          end
        end
        wr = wr + CW'(1);
      end
      if (err_push) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr) begin
            f_inst_d[i] = '0;
            f_pc_d[i]   = pc_q;
            f_err_d[i]  = 1'b1;
          end
        end
        wr = wr + CW'(1);
      end
      count_d = wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      f_inst_q   <= '0;
      f_pc_q     <= '0;
      f_err_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      f_inst_q   <= f_inst_d;
      f_pc_q     <= f_pc_d;
      f_err_q    <= f_err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized handshake, redirect and
// reset traffic. A negedge monitor compares every accepted instruction against a queue of
// expected entries derived from the fetch-window rules.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          DEPTH    = 2;
  // Memory returns a scrambled copy of the byte address so that words are distinguishable.
  localparam logic [31:0] SCR      = 32'h5A5A_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_en;
  logic [10:0] im_addr;
  logic [31:0] im_dout;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  int n_checks = 0;
  int n_fail = 0;
  int n_delivered = 0;

  ent_t        exp_q[$];
  ent_t        e;
  logic [31:0] gen_pc = RESET_PC;
  logic [31:0] fetch_pc = RESET_PC;
  bit          gen_done = 1'b0;
  int          outstanding = 0;
  bit          pop_now;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_en       (im_en),
    .im_addr     (im_addr),
    .im_dout     (im_dout),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_err    (inst_err)
  );

  // Instruction memory: garbage on cycles without a request exposes killed fetches.
  always @(posedge clk) begin
    if (im_en) im_dout <= {19'h0, im_addr, 2'b00} ^ SCR;
    else       im_dout <= $urandom();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= RESET_PC) && (a < RESET_PC + 32'h2000);
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    case ($urandom_range(0, 4))
      0, 1:    p = RESET_PC + ($urandom_range(0, 2047) << 2);
      2:       p = RESET_PC + 32'h2000 - ($urandom_range(1, 6) << 2);
      3:       p = RESET_PC + $urandom_range(0, 8191);
      default: p = $urandom();
    endcase
    return p;
  endfunction

  task automatic model_restart(input logic [31:0] p);
    exp_q.delete();
    gen_pc      = p;
    fetch_pc    = p;
    gen_done    = 1'b0;
    outstanding = 0;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_restart(RESET_PC);
    end else begin
      pop_now = inst_valid && inst_ready && !redirect;
      if (redirect) begin
        check("im_en_during_redirect", 32'(im_en), 32'd0);
      end else if (im_en) begin
        check("im_addr", 32'(im_addr), 32'(fetch_pc[12:2]));
        check("issue_pc_legal", 32'(legal(fetch_pc)), 32'd1);
        check("occupancy", 32'((outstanding - int'(pop_now)) < DEPTH), 32'd1);
        fetch_pc = fetch_pc + 32'd4;
        outstanding++;
      end
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h, required no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst", inst, e.inst);
          check("inst_pc", inst_pc, e.pc);
          check("inst_err", 32'(inst_err), 32'(e.err));
          if (!e.err) outstanding--;
          n_delivered++;
        end
      end
      if (redirect) model_restart(redirect_pc);
      while (!gen_done && exp_q.size() < 8) begin
        if (legal(gen_pc)) begin
          exp_q.push_back('{inst: (gen_pc & 32'h0000_1FFC) ^ SCR, pc: gen_pc, err: 1'b0});
          gen_pc = gen_pc + 32'd4;
        end else begin
          exp_q.push_back('{inst: 32'h0, pc: gen_pc, err: 1'b1});
          gen_done = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] last_pc;
    bit          found;

    // Reset values and first issue.
    step();
    step();
    #1;
    check("reset_im_en", 32'(im_en), 32'd0);
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_inst", inst, 32'd0);
    check("reset_inst_pc", inst_pc, 32'd0);
    check("reset_inst_err", 32'(inst_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("first_issue_en", 32'(im_en), 32'd1);
    check("first_issue_addr", 32'(im_addr), 32'(RESET_PC[12:2]));
    step();
    check("latency_t1_valid", 32'(inst_valid), 32'd0);
    step();
    check("latency_t2_valid", 32'(inst_valid), 32'd1);
    check("seq_pc0", inst_pc, 32'h3000);
    step();
    check("seq_valid1", 32'(inst_valid), 32'd1);
    check("seq_pc1", inst_pc, 32'h3004);
    step();
    check("seq_valid2", 32'(inst_valid), 32'd1);
    check("seq_pc2", inst_pc, 32'h3008);

    // Backpressure right after the first valid.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("stall_first_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold_valid", 32'(inst_valid), 32'd1);
      check("stall_hold_pc", inst_pc, 32'h3000);
    end
    check("stall_im_en", 32'(im_en), 32'd0);
    inst_ready = 1'b1;
    repeat (4) step();

    // Redirect with fetch in flight.
    redirect    = 1'b1;
    redirect_pc = 32'h3100;
    inst_ready  = 1'b0;
    #1;
    check("redirect_im_en", 32'(im_en), 32'd0);
    step();
    redirect   = 1'b0;
    inst_ready = 1'b1;
    #1;
    check("redirect_flushed", 32'(inst_valid), 32'd0);
    check("redirect_issue", 32'(im_en), 32'd1);
    check("redirect_addr", 32'(im_addr), (32'h3100 >> 2) & 32'h7FF);
    step();
    step();
    check("redirect_deliver_valid", 32'(inst_valid), 32'd1);
    check("redirect_deliver_pc", inst_pc, 32'h3100);

    // Misaligned redirect: one error marker, then halt.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h3102;
    inst_ready  = 1'b0;
    step();
    redirect = 1'b0;
    #1;
    check("misalign_im_en", 32'(im_en), 32'd0);
    step();
    check("misalign_valid", 32'(inst_valid), 32'd1);
    check("misalign_err", 32'(inst_err), 32'd1);
    check("misalign_inst", inst, 32'd0);
    check("misalign_pc", inst_pc, 32'h3102);
    check("misalign_halt_en", 32'(im_en), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_im_en", 32'(im_en), 32'd0);
      check("halt_valid", 32'(inst_valid), 32'd0);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    #1;
    check("resume_im_en", 32'(im_en), 32'd1);
    check("resume_addr", 32'(im_addr), 32'(RESET_PC[12:2]));

    // Run off the end of the window.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h4FF0;
    step();
    redirect = 1'b0;
    last_pc  = '0;
    found    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (inst_valid && inst_err) begin
        found = 1'b1;
        break;
      end
      if (inst_valid) last_pc = inst_pc;
    end
    check("window_end_found", 32'(found), 32'd1);
    check("window_end_err_pc", inst_pc, 32'h5000);
    check("window_end_last_pc", last_pc, 32'h4FFC);

    // Asynchronous reset mid-stream.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(inst_valid), 32'd0);
    check("async_reset_im_en", 32'(im_en), 32'd0);
    check("async_reset_inst", inst, 32'd0);
    check("async_reset_inst_pc", inst_pc, 32'd0);
    check("async_reset_err", 32'(inst_err), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("restart_im_en", 32'(im_en), 32'd1);
    check("restart_addr", 32'(im_addr), 32'(RESET_PC[12:2]));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      inst_ready  = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 99) < 3);
      redirect_pc = rand_pc();
      if ($urandom_range(0, 599) == 0) begin
        redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rand_reset_valid", 32'(inst_valid), 32'd0);
        step();
        rst_n = 1'b1;
      end
    end
    redirect   = 1'b0;
    inst_ready = 1'b1;
    repeat (10) step();
    check("progress", 32'(n_delivered > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
